// File: rtl/calculator_pkg.sv
// -----------------------------------------------------------------------------
// calculator_pkg
// Shared definitions for the CH4 calculator front end and datapath:
//   - button index constants into the 5-bit button vectors
//   - command FSM state type for calculator_input
//   - helper that tests a button vector for exactly one set bit
// -----------------------------------------------------------------------------
package calculator_pkg;

    localparam int BTN_COUNT = 5;

    localparam int CENTER = 0;
    localparam int UP     = 1;
    localparam int LEFT   = 2;
    localparam int RIGHT  = 3;
    localparam int DOWN   = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HELD = 1'b1
    } input_state_t;

    // True when exactly one bit of v is set
    function automatic logic is_one_hot(input logic [BTN_COUNT-1:0] v);
        return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
    endfunction

endpackage

// File: rtl/calculator_input_debounce.sv
// -----------------------------------------------------------------------------
// debounce
// Synchronizes one raw asynchronous button bit and accepts a level change
// only after the synchronized value has disagreed with the current debounced
// level for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset, clears chain, counter and level
//   raw   - raw bouncy button input, asynchronous to clk
//   level - debounced level, synchronous to clk
// -----------------------------------------------------------------------------
module debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    // The accepting cycle is the one whose increment would reach
    // DEBOUNCE_CYCLES, so the counter itself never holds that value.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   level_r;
    logic                   sync_s;

    assign sync_s = sync_r[SYNC_STAGES-1];
    assign level  = level_r;

    // Metastability chain: raw enters at bit 0, synchronized value leaves at the top
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
        end
    end

    // Stability counter: any agreement restarts the count, a full run of
    // disagreement flips the debounced level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= '0;
            level_r <= 1'b0;
        end else if (sync_s == level_r) begin
            cnt_r   <= '0;
            level_r <= level_r;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r   <= '0;
            level_r <= sync_s;
        end else begin
            cnt_r   <= cnt_r + CNT_ONE;
            level_r <= level_r;
        end
    end

endmodule

// File: rtl/calculator_input.sv
// -----------------------------------------------------------------------------
// calculator_input
// Board-pin conditioner producing the calculator command interface.
// Ports:
//   clk     - system clock (single clock domain)
//   rst_n   - asynchronous active-low reset
//   btn_raw - 5 raw active-high pushbuttons (CENTER/UP/LEFT/RIGHT/DOWN)
//   sw_raw  - 16 raw slide switches
//   start   - one-cycle strobe for a newly accepted single-button command
//   buttons - one-hot button of the last start, held until the next start
//   switch  - signed switch operand captured with start, held until next start
//   chord   - one-cycle strobe when a multi-button press is rejected
// -----------------------------------------------------------------------------
module calculator_input
    import calculator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BTN_COUNT-1:0]  btn_raw,
    input  logic [15:0]           sw_raw,
    output logic                  start,
    output logic [BTN_COUNT-1:0]  buttons,
    output logic signed [15:0]    switch,
    output logic                  chord
);

    logic [BTN_COUNT-1:0]         level_s;
    logic [BTN_COUNT-1:0]         prev_level_r;
    logic [BTN_COUNT-1:0]         rise_s;
    logic [SYNC_STAGES-1:0][15:0] sw_sync_r;
    input_state_t                 state_r;
    input_state_t                 state_nxt_s;
    logic                         start_nxt_s;
    logic                         chord_nxt_s;
    logic                         start_r;
    logic                         chord_r;
    logic [BTN_COUNT-1:0]         buttons_r;
    logic signed [15:0]           switch_r;

    for (genvar i = 0; i < BTN_COUNT; i++) begin : g_btn
        debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_debounce (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (btn_raw[i]),
            .level (level_s[i])
        );
    end

    // Switch bus synchronizer; switches are levels, so no debounce is applied
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_sync_r <= '0;
        end else begin
            sw_sync_r <= {sw_sync_r[SYNC_STAGES-2:0], sw_raw};
        end
    end

    // Previous debounced levels for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_level_r <= '0;
        end else begin
            prev_level_r <= level_s;
        end
    end

    // Command FSM: accept a lone press in IDLE, reject chords, then wait in
    // HELD until every button is released so one press gives one command
    always_comb begin
        rise_s      = level_s & ~prev_level_r;
        state_nxt_s = state_r;
        start_nxt_s = 1'b0;
        chord_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (rise_s != 5'd0) begin
                    // A rise is only a clean command if nothing else is down
                    if (is_one_hot(rise_s) && (level_s == rise_s)) begin
                        start_nxt_s = 1'b1;
                    end else begin
                        chord_nxt_s = 1'b1;
                    end
                    state_nxt_s = HELD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HELD: begin
                if (level_s == 5'd0) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HELD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered command outputs; operand and button captured only with start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_r   <= 1'b0;
            chord_r   <= 1'b0;
            buttons_r <= '0;
            switch_r  <= '0;
        end else begin
            start_r <= start_nxt_s;
            chord_r <= chord_nxt_s;
            if (start_nxt_s) begin
                buttons_r <= rise_s;
                switch_r  <= signed'(sw_sync_r[SYNC_STAGES-1]);
            end else begin
                buttons_r <= buttons_r;
                switch_r  <= switch_r;
            end
        end
    end

    assign start   = start_r;
    assign chord   = chord_r;
    assign buttons = buttons_r;
    assign switch  = switch_r;

endmodule

// File: tb/tb_calculator_input.sv
// -----------------------------------------------------------------------------
// tb_calculator_input
// Directed bench for calculator_input with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// A behavioural model says a button's accepted level flips once the raw input
// has sat at the other value for DEBOUNCE_CYCLES sampled edges (seen
// SYNC_STAGES-1 edges late), and derives start/chord/buttons/switch from the
// press rules. It is compared with the DUT every cycle; literal expectations
// from the scenario list pin the model.
// -----------------------------------------------------------------------------
module tb_calculator_input;

    localparam int D = 4;
    localparam int S = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [4:0]         btn_raw = 5'd0;
    logic [15:0]        sw_raw = 16'd0;
    logic               start;
    logic [4:0]         buttons;
    logic signed [15:0] switch;
    logic               chord;

    calculator_input #(
        .DEBOUNCE_CYCLES (D),
        .SYNC_STAGES     (S)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_raw),
        .sw_raw  (sw_raw),
        .start   (start),
        .buttons (buttons),
        .switch  (switch),
        .chord   (chord)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int start_cnt = 0;
    int chord_cnt = 0;

    // model state
    logic [4:0]  raw_q[$];
    logic [4:0]  sync_q[$];
    logic [15:0] sw_q[$];
    logic [4:0]  m_lvl = 5'd0;
    logic [4:0]  m_prev = 5'd0;
    logic [15:0] m_sw = 16'd0;
    bit          m_held = 1'b0;
    logic        e_start = 1'b0;
    logic        e_chord = 1'b0;
    logic [4:0]  e_buttons = 5'd0;
    logic [15:0] e_switch = 16'd0;
    logic [4:0]  rise;
    logic [4:0]  flip;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        raw_q = {};
        sync_q = {};
        sw_q = {};
        for (int i = 0; i < S - 1; i++) begin
            raw_q.push_back(5'd0);
            sw_q.push_back(16'd0);
        end
        for (int i = 0; i < D; i++) sync_q.push_back(5'd0);
        m_lvl = 5'd0;
        m_prev = 5'd0;
        m_sw = 16'd0;
        m_held = 1'b0;
        e_start = 1'b0;
        e_chord = 1'b0;
        e_buttons = 5'd0;
        e_switch = 16'd0;
    endtask

    // Model step at each edge, then the per-cycle comparison
    always @(posedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            rise = m_lvl & ~m_prev;
            e_start = 1'b0;
            e_chord = 1'b0;
            if (!m_held) begin
                if (rise != 5'd0) begin
                    if ($countones(rise) == 1 && m_lvl == rise) begin
                        e_start = 1'b1;
                        e_buttons = rise;
                        e_switch = m_sw;
                    end else begin
                        e_chord = 1'b1;
                    end
                    m_held = 1'b1;
                end
            end else if (m_lvl == 5'd0) begin
                m_held = 1'b0;
            end
            // a level flips when the last D synchronized samples all disagree
            flip = 5'h1F;
            foreach (sync_q[j]) flip &= sync_q[j] ^ m_lvl;
            m_prev = m_lvl;
            m_lvl = m_lvl ^ flip;
            raw_q.push_back(btn_raw);
            sync_q.push_back(raw_q.pop_front());
            void'(sync_q.pop_front());
            sw_q.push_back(sw_raw);
            m_sw = sw_q.pop_front();
        end
        #1;
        if (start === 1'b1) start_cnt++;
        if (chord === 1'b1) chord_cnt++;
        n_cmp++;
        if ({start, chord, buttons, switch} !== {e_start, e_chord, e_buttons, e_switch}) begin
            n_err++;
            $display("FAIL model_cmp: got start=%b chord=%b buttons=%b switch=%0h expected start=%b chord=%b buttons=%b switch=%0h (t=%0t)",
                     start, chord, buttons, switch, e_start, e_chord, e_buttons, e_switch, $time);
        end
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int s0;
        int c0;
        // reset with everything asserted on the pins
        rst_n = 1'b0;
        btn_raw = 5'h1F;
        sw_raw = 16'hFFFF;
        edges(3);
        check("rst_start", 16'(start), 16'd0);
        check("rst_chord", 16'(chord), 16'd0);
        check("rst_buttons", 16'(buttons), 16'd0);
        check("rst_switch", switch, 16'd0);
        @(negedge clk);
        btn_raw = 5'd0;
        sw_raw = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(10);

        // clean LEFT press with operand 5
        s0 = start_cnt;
        btn_raw = 5'b00100;
        sw_raw = 16'h0005;
        edges(6);
        check("press_early", 16'(start), 16'd0);
        edges(1);
        check("press_start", 16'(start), 16'd1);
        check("press_buttons", 16'(buttons), 16'h0004);
        check("press_switch", switch, 16'h0005);
        edges(1);
        check("press_strobe_len", 16'(start), 16'd0);
        @(negedge clk);
        sw_raw = 16'hFFFD;
        idle_cycles(100);
        check("press_single", 16'(start_cnt - s0), 16'd1);
        check("operand_hold", switch, 16'h0005);
        btn_raw = 5'd0;
        idle_cycles(20);

        // CENTER press picks up the new operand
        btn_raw = 5'b00001;
        edges(7);
        check("center_start", 16'(start), 16'd1);
        check("center_buttons", 16'(buttons), 16'h0001);
        check("center_switch", switch, 16'hFFFD);
        @(negedge clk);
        btn_raw = 5'd0;
        idle_cycles(20);

        // UP bouncing every 2 cycles for 12 cycles, then steady
        s0 = start_cnt;
        for (int c = 0; c < 12; c++) begin
            btn_raw = (((c / 2) % 2) == 0) ? 5'b00010 : 5'b00000;
            @(negedge clk);
        end
        btn_raw = 5'b00010;
        edges(6);
        check("bounce_early", 16'(start), 16'd0);
        edges(1);
        check("bounce_start", 16'(start), 16'd1);
        check("bounce_buttons", 16'(buttons), 16'h0002);
        idle_cycles(10);
        check("bounce_single", 16'(start_cnt - s0), 16'd1);
        btn_raw = 5'd0;
        idle_cycles(20);

        // UP+DOWN chord
        s0 = start_cnt;
        c0 = chord_cnt;
        sw_raw = 16'h1234;
        btn_raw = 5'b10010;
        idle_cycles(20);
        check("chord_pulses", 16'(chord_cnt - c0), 16'd1);
        check("chord_no_start", 16'(start_cnt - s0), 16'd0);
        check("chord_buttons", 16'(buttons), 16'h0002);
        check("chord_switch", switch, 16'hFFFD);
        btn_raw = 5'd0;
        idle_cycles(20);

        // lone DOWN after the chord
        btn_raw = 5'b10000;
        edges(7);
        check("down_start", 16'(start), 16'd1);
        check("down_buttons", 16'(buttons), 16'h0010);
        check("down_switch", switch, 16'h1234);
        @(negedge clk);
        btn_raw = 5'd0;
        idle_cycles(20);

        // reset two counts into an UP debounce, button released during reset
        s0 = start_cnt;
        c0 = chord_cnt;
        btn_raw = 5'b00010;
        idle_cycles(4);
        rst_n = 1'b0;
        btn_raw = 5'd0;
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(20);
        check("rstmid_no_start", 16'(start_cnt - s0), 16'd0);
        check("rstmid_no_chord", 16'(chord_cnt - c0), 16'd0);
        check("rstmid_buttons", 16'(buttons), 16'd0);
        check("rstmid_switch", switch, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/calculator_input.md
# calculator_input

Front-end conditioner for the CH4 calculator datapath. Takes the five raw board pushbuttons and the 16 raw slide switches and produces the calculator's command interface. That interface is a single-cycle `start` strobe, a one-hot `buttons` vector and a registered signed `switch` operand, all synchronous to `clk`. The block sits between the board pins and the calculator FSM. It is the producing end of the `start`/`buttons`/`switch` interface the calculator consumes.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable cycles required to accept a button level change (2.5 ms at 100 MHz).
- `SYNC_STAGES`, default 2: synchronizer flops per raw input, minimum 2.
- `clk` in 1: system clock; all logic is single-clock.
- `rst_n` in 1: reset, asynchronous assert, active-low; all flops clear on assertion.
- `btn_raw` in 5: raw pushbuttons, active-high, asynchronous to `clk`, bouncy.
- `sw_raw` in 16: raw slide switches, asynchronous to `clk`.
- `start` out 1: one-cycle strobe marking a new accepted command.
- `buttons` out 5: one-hot button that caused the last `start`; held until the next `start`.
- `switch` out 16 signed: synchronized switch value captured on the `start` cycle; held until the next `start`.
- `chord` out 1: one-cycle strobe when a multi-button press is rejected.

## Operation
- Button indices come from `calculator_pkg`: CENTER=0, UP=1, LEFT=2, RIGHT=3, DOWN=4.
- **Synchronization**
  - Each `btn_raw` bit passes through its own `SYNC_STAGES` flop chain.
  - `sw_raw` passes through a `SYNC_STAGES` chain as a bus.
  - Switches are not debounced.
- **Debounce, per button**
  - A counter of width `$clog2(DEBOUNCE_CYCLES+1)` clears whenever the synchronized level equals the debounced level.
  - Otherwise the counter increments.
  - When it reaches `DEBOUNCE_CYCLES`, the debounced level takes the synchronized value and the counter clears.
  - Any mismatch gap restarts the count from 0.
- **Command FSM**
  - IDLE
    - The rising set of debounced levels is computed as (level AND NOT previous level).
    - Exactly one bit rising, with no other debounced button held: assert `start`, load `buttons` with that one-hot value, load `switch` from the synchronized switches. Go to HELD.
    - Two or more bits rising in the same cycle, or a rise while another button is already held: assert `chord`, leave `start` and the outputs unchanged. Go to HELD.
  - HELD
    - Stay in HELD while any debounced level is 1.
    - When all debounced levels are 0, go to IDLE on the next edge.
    - No `start` or `chord` is issued in HELD.
- `start` and `chord` are never asserted in the same cycle.
- **Reset values:** `start`=0, `chord`=0, `buttons`=0, `switch`=0, debounced levels=0, counters=0, synchronizers=0, state=IDLE.

## Timing
- **Press latency:** for a raw press that stays steady from edge N, `start` is high during the cycle after edge N+SYNC_STAGES+DEBOUNCE_CYCLES.
  - Breakdown: SYNC_STAGES to synchronize, DEBOUNCE_CYCLES to accept, 1 to register the strobe.
- **Release latency:** the same path applies before HELD returns to IDLE.
- **Bounces:** glitches shorter than DEBOUNCE_CYCLES cycles never change the debounced level.
- **Operand sampling:** `switch` equals the synchronized switch value on the edge that raises `start`. Later switch movement does not change `switch` until the next `start`.
- **Reset mid-operation:** reset during debounce or HELD discards all progress. No `start` results from a press that was partially counted before reset.
- **Held through reset:** a button held through reset release is treated as a new press and produces a `start` after full latency.
- **Counter behaviour:** counters saturate by construction, since they clear on reaching the limit, so there is no wrap-around.

## Structure
- `calculator_pkg` holds the button index constants (CENTER/UP/LEFT/RIGHT/DOWN) and the new state enum `input_state_t` {IDLE, HELD}.
- One sub-module, `debounce`, is instantiated 5×.
  - It contains the synchronizer and counter for one bit.
  - Ports: `clk`, `rst_n`, `raw`, `level`; parameters `DEBOUNCE_CYCLES`, `SYNC_STAGES`.
- The top level contains the switch synchronizer, rise detection, FSM and output registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and SYNC_STAGES=2.
- **Reset:** hold `rst_n`=0 with `btn_raw`=5'h1F and `sw_raw`=16'hFFFF. All outputs are 0 during reset.
- **Clean press:** set `sw_raw`=16'h0005 and raise `btn_raw`[2] (LEFT) steadily at edge 0.
  - `start`=1 for exactly one cycle after edge 6, with `buttons`=5'b00100 and `switch`=5.
  - Holding LEFT for 100 more cycles produces no further `start`.
- **Bounce:** toggle `btn_raw`[1] every 2 cycles for 12 cycles, then hold it high.
  - Exactly one `start`, with `buttons`=5'b00010, 7 cycles after the steady level begins.
- **Chord:** raise `btn_raw`[1] and `btn_raw`[4] on the same edge.
  - One `chord` pulse, no `start`, `buttons`/`switch` unchanged.
  - After both are released, a single DOWN press yields `start` with `buttons`=5'b10000.
- **Operand hold:** after a `start` with `switch`=5, change `sw_raw` to 16'hFFFD.
  - `switch` stays 5.
  - After release and a CENTER press, `start` shows `buttons`=5'b00001 and `switch`=-3.
- **Reset mid-debounce:** pulse `rst_n` low 2 cycles into the UP debounce count, then release `btn_raw` before acceptance.
  - No `start` and no `chord` occur.
